// File: rtl/mac_result_collector.sv
// mac_result_collector: credit-tracked result FIFO behind an 11-stage MAC pipeline.
// Optional MAC_COLLECT_ERR_DROP_EN discards errored results instead of storing them.
module mac_result_collector #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_in,
    output logic             issue_ok,
    input  logic             store_valid_in,
    input  logic [63:0]      res_in,
    input  logic             error_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_data,
    output logic             out_err,
    output logic [CNT_W-1:0] result_cnt,
    output logic             overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
`ifdef MAC_COLLECT_ERR_DROP_EN
    localparam int EW = 64;
`else
    localparam int EW = 65;
`endif

    logic [AW:0]   occ, infl;
    logic [AW-1:0] wptr, rptr;
    logic [EW-1:0] mem [DEPTH];
    logic [AW+1:0] used;
    logic          full, pop, push_req, push, lost;

    assign used      = {1'b0, occ} + {1'b0, infl};
    assign issue_ok  = used < {1'b0, DEPTH_V};
    assign full      = occ == DEPTH_V;
    assign out_valid = occ != '0;
    assign pop       = out_valid && out_ready;
`ifdef MAC_COLLECT_ERR_DROP_EN
    assign push_req  = store_valid_in && !error_in;
    assign out_err   = 1'b0;
    assign out_data  = out_valid ? mem[rptr] : '0;
`else
    assign push_req  = store_valid_in;
    assign {out_err, out_data} = out_valid ? mem[rptr] : '0;
`endif
    // A full FIFO can still take a result if the head leaves in the same cycle.
    assign push = push_req && (!full || pop);
    assign lost = (push_req && !push) || (issue_in && !issue_ok) ||
                  (store_valid_in && !issue_in && infl == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ        <= '0;
            infl       <= '0;
            wptr       <= '0;
            rptr       <= '0;
            result_cnt <= '0;
            overflow   <= 1'b0;
        end else begin
            occ <= occ + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
            if (issue_in && !store_valid_in && infl != DEPTH_V)
                infl <= infl + 1'b1;
            else if (!issue_in && store_valid_in && infl != '0)
                infl <= infl - 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
            if (push) result_cnt <= result_cnt + 1'b1;
            if (lost) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
`ifdef MAC_COLLECT_ERR_DROP_EN
        if (push) mem[wptr] <= res_in;
`else
        if (push) mem[wptr] <= {error_in, res_in};
`endif
    end
endmodule

// File: tb/tb_mac_result_collector.sv
// tb_mac_result_collector: directed + random checks against a queue-based reference model.
module tb_mac_result_collector;
    localparam int DEPTH = 16;

    logic        clk = 0, rst = 1;
    logic        issue_in = 0, store_valid_in = 0, error_in = 0, out_ready = 0;
    logic [63:0] res_in = '0;
    logic        issue_ok, out_valid, out_err, overflow;
    logic [63:0] out_data;
    logic [15:0] result_cnt;

    mac_result_collector #(.DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .issue_in(issue_in), .issue_ok(issue_ok),
        .store_valid_in(store_valid_in), .res_in(res_in), .error_in(error_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_err(out_err), .result_cnt(result_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    logic [64:0] q[$];
    int          infl;
    bit          ovf;
    logic [15:0] cnt;
    int          checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [64:0] head;
        head = (q.size() > 0) ? q[0] : '0;
        chk({tag, ".issue_ok"}, 64'(issue_ok), 64'((q.size() + infl) < DEPTH));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() > 0));
        chk({tag, ".out_data"}, out_data, head[63:0]);
`ifdef MAC_COLLECT_ERR_DROP_EN
        chk({tag, ".out_err"}, 64'(out_err), 64'd0);
`else
        chk({tag, ".out_err"}, 64'(out_err), 64'(head[64]));
`endif
        chk({tag, ".result_cnt"}, 64'(result_cnt), 64'(cnt));
        chk({tag, ".overflow"}, 64'(overflow), 64'(ovf));
    endtask

    task automatic cyc(input string tag, input bit iss, input bit st, input logic [63:0] r,
                       input bit e, input bit rdy);
        bit ok, pop, full, pr;
        issue_in = iss; store_valid_in = st; res_in = r; error_in = e; out_ready = rdy;
        ok   = (q.size() + infl) < DEPTH;
        pop  = (q.size() > 0) && rdy;
        full = q.size() == DEPTH;
        if (iss && !ok) ovf = 1;
        if (iss && !st) begin
            if (infl < DEPTH) infl++;
        end else if (st && !iss) begin
            if (infl == 0) ovf = 1; else infl--;
        end
        pr = st;
`ifdef MAC_COLLECT_ERR_DROP_EN
        pr = st && !e;
`endif
        if (pop) void'(q.pop_front());
        if (pr) begin
            if (!full || pop) begin
                q.push_back({e, r});
                cnt++;
            end else ovf = 1;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic do_reset(input string tag);
        rst = 1;
        issue_in = 0; store_valid_in = 0; error_in = 0; out_ready = 0; res_in = '0;
        #1;
        q.delete(); infl = 0; ovf = 0; cnt = '0;
        check_all({tag, ".async"});
        @(posedge clk);
        #1;
        rst = 0;
        check_all(tag);
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        do_reset("reset");

        // Single op through the 11-cycle pipeline
        cyc("single_issue", 1, 0, '0, 0, 1);
        for (int i = 0; i < 10; i++) cyc("single_wait", 0, 0, '0, 0, 1);
        cyc("single_store", 0, 1, 64'h3FF0000000000000, 0, 1);
        chk("single_out_data", out_data, 64'h3FF0000000000000);
        chk("single_cnt", 64'(result_cnt), 64'd1);
        cyc("single_pop", 0, 0, '0, 0, 1);

        // Fill credits and FIFO
        for (int i = 0; i < 16; i++) cyc("fill_issue", 1, 0, '0, 0, 0);
        chk("fill_issue_ok_low", 64'(issue_ok), 64'd0);
        for (int i = 0; i < 16; i++) cyc("fill_store", 0, 1, rnd64(), 0, 0);
        chk("fill_overflow0", 64'(overflow), 64'd0);

        // Push into full FIFO: dropped without pop, accepted with pop
        cyc("full_drop", 0, 1, rnd64(), 0, 0);
        cyc("full_swap", 0, 1, rnd64(), 0, 1);
        for (int i = 0; i < 18; i++) cyc("drain", 0, 0, '0, 0, 1);

        // Errored result
        do_reset("reset_err");
        cyc("err_issue", 1, 0, '0, 0, 0);
        cyc("err_store", 0, 1, 64'hC000000000000000, 1, 0);
        cyc("err_pop", 0, 0, '0, 0, 1);

        // Reset mid-operation: 5 stored, 3 in flight
        do_reset("reset_mid0");
        for (int i = 0; i < 8; i++) cyc("mid_issue", 1, 0, '0, 0, 0);
        for (int i = 0; i < 5; i++) cyc("mid_store", 0, 1, rnd64(), 0, 0);
        do_reset("reset_mid");
        chk("mid_out_valid", 64'(out_valid), 64'd0);
        chk("mid_issue_ok", 64'(issue_ok), 64'd1);
        cyc("mid_stray", 0, 1, rnd64(), 0, 0);
        chk("mid_overflow", 64'(overflow), 64'd1);

        // 20 push/pop pairs across pointer wrap
        do_reset("reset_wrap");
        cyc("wrap_issue0", 1, 0, '0, 0, 0);
        for (int i = 0; i < 20; i++) cyc("wrap_pair", i < 19, 1, rnd64(), 0, i[0]);
        for (int i = 0; i < 12; i++) cyc("wrap_drain", 0, 0, '0, 0, 1);
        chk("wrap_cnt20", 64'(result_cnt), 64'd20);

        // Randomized traffic
        do_reset("reset_rand");
        for (int i = 0; i < 400; i++) begin
            bit iss, st;
            iss = ((q.size() + infl) < DEPTH) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 15) == 0);
            st  = (infl > 0) ? bit'($urandom_range(0, 1)) : ($urandom_range(0, 31) == 0);
            cyc("rand", iss, st, rnd64(), $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
